// File: rtl/ov7670_cfg_sequencer.sv
// OV7670 boot-time register configurator.
// Walks a synchronous ROM of {reg_addr, value} entries and issues one i2c
// write per entry through i2c_master. Supports inline millisecond delays,
// per-entry NACK retry and sticky done/error status.
//
// Entry encoding:
//   16'hFFFF  end of table
//   16'hF0nn  delay nn milliseconds (nn = 0 means no delay)
//   other     write val[7:0] to reg[15:8]
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | not running, waiting for i_start
// S_FETCH  | o_rom_addr driven, ROM data arrives on the next cycle
// S_DECODE | classify entry; a write waits here until the master is idle
// S_ISSUE  | o_wr held until i_busy is seen or the ack timeout expires
// S_WAIT   | frame in flight, collecting NACK flags until i_busy falls
// S_CHECK  | advance, retry the same entry, or give up
// S_DELAY  | millisecond delay countdown
// S_DONE   | table completed, o_done sticky
// S_ERROR  | entry failed after all retries, o_error sticky

module ov7670_cfg_sequencer #(
  parameter int         T_CLK       = 20,
  parameter int         ROM_AW      = 8,
  parameter logic [6:0] SLAVE_ADDR  = 7'h21,
  parameter int         MAX_RETRY   = 3,
  parameter int         ACK_TIMEOUT = 16,
  parameter int         AUTO_START  = 1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic              o_wr,
  output logic [6:0]        o_slave_addr,
  output logic [7:0]        o_reg_addr,
  output logic [7:0]        o_wdata,
  input  logic              i_busy,
  input  logic              i_nack_slave,
  input  logic              i_nack_addr,
  input  logic              i_nack_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ROM_AW-1:0] o_err_index
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_DELAY,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int MS_CYCLES = 1_000_000 / T_CLK;
  localparam int RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int TW        = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

  localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [TW-1:0]     TMO_LOAD  = TW'(ACK_TIMEOUT - 1);
  localparam logic [31:0]       MS_C      = 32'(MS_CYCLES);
  localparam logic [ROM_AW-1:0] LAST_ADDR = '1;
  localparam state_t            RST_STATE = (AUTO_START != 0) ? S_FETCH : S_IDLE;

  state_t            state;
  logic [RW-1:0]     retry_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic [31:0]       dly_cnt;
  logic              nack_seen;

  logic              ent_end;
  logic              ent_dly;
  logic              nack_any;

  assign ent_end  = (i_rom_data == 16'hFFFF);
  assign ent_dly  = (i_rom_data[15:8] == 8'hF0);
  assign nack_any = i_nack_slave | i_nack_addr | i_nack_data;

  // Sequencer FSM with registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state        <= RST_STATE;
      o_rom_addr   <= '0;
      o_wr         <= 1'b0;
      o_slave_addr <= '0;
      o_reg_addr   <= '0;
      o_wdata      <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_err_index  <= '0;
      retry_cnt    <= '0;
      tmo_cnt      <= '0;
      dly_cnt      <= '0;
      nack_seen    <= 1'b0;
    end else begin
      o_slave_addr <= SLAVE_ADDR;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_start) begin
            o_rom_addr  <= '0;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
            o_err_index <= '0;
            retry_cnt   <= '0;
            o_busy      <= 1'b1;
            state       <= S_FETCH;
          end
        end

        S_FETCH: begin
          o_busy <= 1'b1;
          state  <= S_DECODE;
        end

        S_DECODE: begin
          if (ent_end) begin
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= S_DONE;
          end else if (ent_dly) begin
            dly_cnt <= {24'd0, i_rom_data[7:0]} * MS_C;
            state   <= S_DELAY;
          end else if (!i_busy) begin
            // a frame left over from before a reset must finish first
            o_reg_addr <= i_rom_data[15:8];
            o_wdata    <= i_rom_data[7:0];
            nack_seen  <= 1'b0;
            retry_cnt  <= '0;
            tmo_cnt    <= TMO_LOAD;
            o_wr       <= 1'b1;
            state      <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (i_busy) begin
            o_wr  <= 1'b0;
            state <= S_WAIT;
          end else if (tmo_cnt == '0) begin
            o_wr      <= 1'b0;
            nack_seen <= 1'b1;
            state     <= S_CHECK;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end

        S_WAIT: begin
          // master clears its NACK flags on the edge busy falls, so keep them
          nack_seen <= nack_seen | nack_any;
          if (!i_busy) state <= S_CHECK;
        end

        S_CHECK: begin
          if (!i_busy) begin
            if (!nack_seen) begin
              retry_cnt <= '0;
              if (o_rom_addr == LAST_ADDR) begin
                o_busy <= 1'b0;
                o_done <= 1'b1;
                state  <= S_DONE;
              end else begin
                o_rom_addr <= o_rom_addr + 1'b1;
                state      <= S_FETCH;
              end
            end else if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + 1'b1;
              nack_seen <= 1'b0;
              tmo_cnt   <= TMO_LOAD;
              o_wr      <= 1'b1;
              state     <= S_ISSUE;
            end else begin
              o_err_index <= o_rom_addr;
              o_error     <= 1'b1;
              o_busy      <= 1'b0;
              state       <= S_ERROR;
            end
          end
        end

        S_DELAY: begin
          if (dly_cnt == '0) begin
            if (o_rom_addr == LAST_ADDR) begin
              o_busy <= 1'b0;
              o_done <= 1'b1;
              state  <= S_DONE;
            end else begin
              o_rom_addr <= o_rom_addr + 1'b1;
              state      <= S_FETCH;
            end
          end else begin
            dly_cnt <= dly_cnt - 1'b1;
          end
        end

        default: state <= RST_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// Scoreboard bench for ov7670_cfg_sequencer: each scenario pushes the
// expected write attempts, a monitor pops one per o_wr rise.
module tb_ov7670_cfg_sequencer;

  localparam int ROM_AW = 4;
  localparam int T_CLK  = 50000;  // 20 cycles per ms keeps delays short
  localparam int FRAME  = 8;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] v;
  } wr_t;

  logic              i_clk = 1'b0;
  logic              i_rstn = 1'b0;
  logic              i_start = 1'b0;
  logic [ROM_AW-1:0] o_rom_addr;
  logic [15:0]       i_rom_data = 16'h0;
  logic              o_wr;
  logic [6:0]        o_slave_addr;
  logic [7:0]        o_reg_addr;
  logic [7:0]        o_wdata;
  logic              i_busy;
  logic              i_nack_slave;
  logic              i_nack_addr;
  logic              i_nack_data;
  logic              o_busy;
  logic              o_done;
  logic              o_error;
  logic [ROM_AW-1:0] o_err_index;

  always #5 i_clk = ~i_clk;

  ov7670_cfg_sequencer #(
    .T_CLK(T_CLK), .ROM_AW(ROM_AW), .SLAVE_ADDR(7'h21),
    .MAX_RETRY(3), .ACK_TIMEOUT(16), .AUTO_START(1)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start),
    .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
    .o_wr(o_wr), .o_slave_addr(o_slave_addr), .o_reg_addr(o_reg_addr),
    .o_wdata(o_wdata), .i_busy(i_busy), .i_nack_slave(i_nack_slave),
    .i_nack_addr(i_nack_addr), .i_nack_data(i_nack_data),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_err_index(o_err_index)
  );

  // synchronous ROM
  logic [15:0] rom [16];
  always @(posedge i_clk) i_rom_data <= rom[o_rom_addr];

  // i2c_master model
  logic       m_busy = 1'b0;
  logic [3:0] m_cnt = 4'd0;
  logic [1:0] m_kind = 2'd0;
  int         m_hits = 0;
  logic       nk_s = 1'b0, nk_a = 1'b0, nk_d = 1'b0;
  logic [7:0] nack_reg = 8'h0;
  logic [1:0] nack_kind = 2'd0;  // 1 slave, 2 addr, 3 data
  int         nack_lim = 0;
  logic       ign_en = 1'b0;
  logic [7:0] ign_reg = 8'h0;
  logic       m_clear = 1'b0;

  assign i_busy       = m_busy;
  assign i_nack_slave = nk_s;
  assign i_nack_addr  = nk_a;
  assign i_nack_data  = nk_d;

  always @(posedge i_clk) begin
    if (m_clear) m_hits <= 0;
    if (!m_busy) begin
      if (o_wr && !(ign_en && o_reg_addr == ign_reg)) begin
        m_busy <= 1'b1;
        m_cnt  <= 4'(FRAME);
        if (nack_kind != 2'd0 && o_reg_addr == nack_reg && m_hits < nack_lim) begin
          m_kind <= nack_kind;
          m_hits <= m_hits + 1;
        end else begin
          m_kind <= 2'd0;
        end
      end
    end else if (m_cnt == 4'd0) begin
      m_busy <= 1'b0;
      nk_s <= 1'b0; nk_a <= 1'b0; nk_d <= 1'b0;
    end else begin
      m_cnt <= m_cnt - 4'd1;
      if (m_cnt == 4'd3) begin
        nk_s <= (m_kind == 2'd1);
        nk_a <= (m_kind == 2'd2);
        nk_d <= (m_kind == 2'd3);
      end
    end
  end

  int  n_cmp = 0;
  int  n_bad = 0;
  int  last_wr_len = 0;
  wr_t exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic       wr_p = 1'b0, bz_p = 1'b0, rst_p = 1'b0;
    logic [7:0] ra_p = 8'h0, wd_p = 8'h0;
    int         len = 0;
    wr_t        e;
    forever begin
      @(negedge i_clk);
      if (o_wr && !wr_p) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_wr: got reg 0x%0h val 0x%0h, required no write (t=%0t)",
                   o_reg_addr, o_wdata, $time);
        end else begin
          e = exp_q.pop_front();
          chk("wr_reg", 32'(o_reg_addr), 32'(e.r));
          chk("wr_val", 32'(o_wdata), 32'(e.v));
          chk("wr_slave", 32'(o_slave_addr), 32'h21);
          chk("wr_while_busy", 32'(i_busy), 32'h0);
        end
      end
      if (i_rstn && rst_p && (wr_p || bz_p) && (o_wr || i_busy)) begin
        chk("stable_reg", 32'(o_reg_addr), 32'(ra_p));
        chk("stable_val", 32'(o_wdata), 32'(wd_p));
      end
      if (o_wr) len++;
      else if (wr_p) begin
        last_wr_len = len;
        len = 0;
      end
      wr_p = o_wr; bz_p = i_busy; rst_p = i_rstn;
      ra_p = o_reg_addr; wd_p = o_wdata;
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
    nack_kind = 2'd0;
    ign_en    = 1'b0;
  endtask

  task automatic expw(input logic [7:0] r, input logic [7:0] v, input int n);
    repeat (n) exp_q.push_back(wr_t'({r, v}));
  endtask

  task automatic do_reset(input int n);
    @(negedge i_clk);
    i_rstn  = 1'b0;
    m_clear = 1'b1;
    repeat (n) @(negedge i_clk);
    m_clear = 1'b0;
    i_rstn  = 1'b1;
  endtask

  task automatic wait_end(input int budget);
    int c = 0;
    while (!(o_done || o_error) && c < budget) begin
      @(negedge i_clk);
      c++;
    end
    chk("end_reached", 32'(o_done | o_error), 32'h1);
  endtask

  task automatic check_end(input string tag, input logic d, input logic e,
                           input logic [ROM_AW-1:0] idx);
    chk({tag, "_done"}, 32'(o_done), 32'(d));
    chk({tag, "_error"}, 32'(o_error), 32'(e));
    chk({tag, "_busy"}, 32'(o_busy), 32'h0);
    chk({tag, "_err_index"}, 32'(o_err_index), 32'(idx));
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    clear_rom();
    fork
      monitor();
    join_none

    // S1: two writes then end
    rom[0] = 16'h1280; rom[1] = 16'h1101;
    expw(8'h12, 8'h80, 1); expw(8'h11, 8'h01, 1);
    i_rstn = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_wr", 32'(o_wr), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_error", 32'(o_error), 0);
    chk("rst_err_index", 32'(o_err_index), 0);
    chk("rst_rom_addr", 32'(o_rom_addr), 0);
    chk("rst_reg_addr", 32'(o_reg_addr), 0);
    chk("rst_wdata", 32'(o_wdata), 0);
    chk("rst_slave", 32'(o_slave_addr), 0);
    i_rstn = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("s1_busy_running", 32'(o_busy), 32'h1);
    wait_end(2000);
    check_end("s1", 1'b1, 1'b0, 4'd0);

    // S2: 10 ms delay (200 cycles) before the single write
    clear_rom();
    rom[0] = 16'hF00A; rom[1] = 16'h3A04;
    expw(8'h3A, 8'h04, 1);
    do_reset(2);
    c = 0;
    while (!o_wr && c < 400) begin
      @(negedge i_clk);
      c++;
    end
    chk("s2_delay_min", 32'(c >= 200), 32'h1);
    chk("s2_delay_max", 32'(c <= 206), 32'h1);
    wait_end(2000);
    check_end("s2", 1'b1, 1'b0, 4'd0);

    // S3: entry 1 NACKs on data twice, then ACKs
    clear_rom();
    rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'h1C7F;
    nack_reg = 8'h11; nack_kind = 2'd3; nack_lim = 2;
    expw(8'h12, 8'h80, 1); expw(8'h11, 8'h01, 3); expw(8'h1C, 8'h7F, 1);
    do_reset(2);
    wait_end(3000);
    check_end("s3", 1'b1, 1'b0, 4'd0);

    // S4: entry 3 always NACKs on the slave address
    clear_rom();
    rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'h1C7F;
    rom[3] = 16'h3E00; rom[4] = 16'h4000;
    nack_reg = 8'h3E; nack_kind = 2'd1; nack_lim = 1000;
    expw(8'h12, 8'h80, 1); expw(8'h11, 8'h01, 1); expw(8'h1C, 8'h7F, 1);
    expw(8'h3E, 8'h00, 4);
    do_reset(2);
    wait_end(3000);
    check_end("s4", 1'b0, 1'b1, 4'd3);
    repeat (40) @(negedge i_clk);
    chk("s4_quiet_wr", 32'(o_wr), 0);
    chk("s4_still_error", 32'(o_error), 32'h1);

    // S5: master ignores entry 1, then restart with i_start
    clear_rom();
    rom[0] = 16'h1280; rom[1] = 16'h2A55;
    ign_en = 1'b1; ign_reg = 8'h2A;
    expw(8'h12, 8'h80, 1); expw(8'h2A, 8'h55, 4);
    do_reset(2);
    wait_end(3000);
    check_end("s5", 1'b0, 1'b1, 4'd1);
    chk("s5_wr_len", 32'(last_wr_len), 32'd16);
    ign_en = 1'b0;
    expw(8'h12, 8'h80, 1); expw(8'h2A, 8'h55, 1);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("s5_restart_error", 32'(o_error), 0);
    chk("s5_restart_busy", 32'(o_busy), 32'h1);
    chk("s5_restart_addr", 32'(o_rom_addr), 0);
    wait_end(2000);
    check_end("s5r", 1'b1, 1'b0, 4'd0);

    // S6: full 16-entry table with a zero delay, finishes at last address
    clear_rom();
    for (int i = 0; i < 16; i++) begin
      if (i == 5) rom[i] = 16'hF000;
      else begin
        rom[i] = {8'(8'h40 + i), 8'(i)};
        expw(8'(8'h40 + i), 8'(i), 1);
      end
    end
    do_reset(2);
    wait_end(4000);
    check_end("s6", 1'b1, 1'b0, 4'd0);
    chk("s6_no_wrap", 32'(o_rom_addr), 32'd15);

    // S7: reset while a frame is in flight
    clear_rom();
    rom[0] = 16'h1280; rom[1] = 16'h1101;
    expw(8'h12, 8'h80, 1);
    do_reset(2);
    c = 0;
    while (!i_busy && c < 100) begin
      @(negedge i_clk);
      c++;
    end
    chk("s7_frame_started", 32'(i_busy), 32'h1);
    @(negedge i_clk);
    i_rstn = 1'b0;
    expw(8'h12, 8'h80, 1); expw(8'h11, 8'h01, 1);
    @(negedge i_clk);
    chk("s7_rst_wr", 32'(o_wr), 0);
    chk("s7_rst_busy", 32'(o_busy), 0);
    chk("s7_rst_reg", 32'(o_reg_addr), 0);
    chk("s7_rst_wdata", 32'(o_wdata), 0);
    chk("s7_rst_addr", 32'(o_rom_addr), 0);
    i_rstn = 1'b1;
    wait_end(2000);
    check_end("s7", 1'b1, 1'b0, 4'd0);

    repeat (5) @(negedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
